clock_divider_prog: RTL

//  Runtime-programmable integer clock divider. Successor to the fixed /2 and /4 divider pair.

---
 rtl/clkdiv_pkg.sv | 19 +
 rtl/clock_divider_prog.sv | 137 +++++++++++++
 2 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider.
//   state_e      : controller state (IDLE, RUN)
//   MIN_RATIO    : smallest usable divide ratio
//   clamp_ratio  : raises any ratio below MIN_RATIO up to MIN_RATIO
package clkdiv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned MIN_RATIO = 2;

    // Ratios 0 and 1 cannot produce a valid high and low phase.
    function automatic int unsigned clamp_ratio(input int unsigned r);
        return (r < MIN_RATIO) ? MIN_RATIO : r;
    endfunction

endpackage

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider.
// clk_out has a period of R input cycles: ceil(R/2) high, then floor(R/2) low.
// tick pulses on the first high cycle of each period. Ratio and enable changes
// only take effect at a period boundary, so clk_out never produces a runt pulse.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   asynchronous, active-high reset
//   en         in   run request, sampled every cycle
//   div_ratio  in   requested divide ratio (0 and 1 clamp to 2)
//   load       in   strobe capturing div_ratio as the pending ratio
//   clk_out    out  divided clock (registered)
//   tick       out  one-cycle pulse on the first high cycle of clk_out (registered)
//   active     out  1 while running (registered)
module clock_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int W             = 8,
    parameter int DEFAULT_RATIO = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_ratio,
    input  logic         load,
    output logic         clk_out,
    output logic         tick,
    output logic         active
);

    localparam logic [W-1:0] DEF_RATIO = W'(DEFAULT_RATIO);

    state_e       state_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] ratio_cur_q;
    logic [W-1:0] ratio_pend_q;
    logic         pend_valid_q;
    logic         clk_out_q;
    logic         tick_q;
    logic         active_q;

    logic [W-1:0] ld_ratio;
    logic [W-1:0] ratio_next_period;
    logic [W-1:0] ratio_eff;
    logic [W-1:0] cnt_d;
    logic [W-1:0] high_len;
    logic         wrap;

    // NOTE: every signal gets a value on every path through this block, so no
    // latch is inferred.
    always_comb begin
        ld_ratio = W'(clamp_ratio(32'(div_ratio)));
        // R >= 2 always, so R-1 cannot underflow.
        wrap     = (cnt_q == ratio_cur_q - W'(1));
        // A load on the wrap cycle bypasses the pending register and applies
        // to the period that starts at this edge.
        ratio_next_period = load         ? ld_ratio     :
                            pend_valid_q ? ratio_pend_q : ratio_cur_q;
        ratio_eff = wrap ? ratio_next_period : ratio_cur_q;
        cnt_d     = wrap ? '0 : cnt_q + W'(1);
        // ceil(R/2) without an extra carry bit, so R = 2**W-1 still fits.
        high_len  = (ratio_eff >> 1) + {{(W-1){1'b0}}, ratio_eff[0]};
    end

    // NOTE: sequential state uses non-blocking assignments only; where two
    // assignments to the same register fall in one branch, the later one wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ratio_cur_q  <= DEF_RATIO;
            ratio_pend_q <= DEF_RATIO;
            pend_valid_q <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q        <= '0;
                    pend_valid_q <= 1'b0;
                    if (load) begin
                        ratio_cur_q  <= ld_ratio;
                        ratio_pend_q <= ld_ratio;
                    end
                    if (en) begin
                        state_q   <= RUN;
                        clk_out_q <= 1'b1;
                        tick_q    <= 1'b1;
                        active_q  <= 1'b1;
                    end else begin
                        clk_out_q <= 1'b0;
                        tick_q    <= 1'b0;
                        active_q  <= 1'b0;
                    end
                end

                RUN: begin
                    if (load) begin
                        ratio_pend_q <= ld_ratio;
                        pend_valid_q <= 1'b1;
                    end
                    if (wrap) begin
                        ratio_cur_q  <= ratio_next_period;
                        pend_valid_q <= 1'b0;
                    end
                    if (wrap && !en) begin
                        // The period just completed; stop cleanly at its end.
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        clk_out_q <= 1'b0;
                        tick_q    <= 1'b0;
                        active_q  <= 1'b0;
                    end else begin
                        cnt_q     <= cnt_d;
                        clk_out_q <= (cnt_d < high_len);
                        tick_q    <= (cnt_d == '0);
                        active_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    clk_out_q <= 1'b0;
                    tick_q    <= 1'b0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign active  = active_q;

endmodule
